// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one ready/valid memory port between instruction fetch and
// load/store. One transaction in flight; each response is routed back to its issuer.
module mem_arbiter #(
    parameter bit PRIORITY_DATA = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_imem_req,
    input  logic [31:0] i_imem_addr,
    output logic        o_imem_gnt,
    output logic        o_imem_valid,
    output logic [31:0] o_imem_rdata,
    input  logic        i_dmem_req,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic        o_dmem_gnt,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wen_q, wen_d;
    logic [3:0]  mask_q, mask_d;
    logic        tag_q, tag_d;            // 1 = data transaction
    logic        last_gnt_q, last_gnt_d;  // 1 = data was granted last
    logic        imem_valid_q, imem_valid_d;
    logic        dmem_valid_q, dmem_valid_d;
    logic [31:0] imem_rdata_q, imem_rdata_d;
    logic [31:0] dmem_rdata_q, dmem_rdata_d;
    logic        any_req, pick_data, imem_gnt, dmem_gnt;

    assign any_req   = i_imem_req | i_dmem_req;
    // On a tie under round-robin, data wins unless it was the last one granted.
    assign pick_data = (i_imem_req & i_dmem_req) ? (PRIORITY_DATA | ~last_gnt_q) : i_dmem_req;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wen_d        = wen_q;
        mask_d       = mask_q;
        tag_d        = tag_q;
        last_gnt_d   = last_gnt_q;
        imem_valid_d = 1'b0;
        dmem_valid_d = 1'b0;
        imem_rdata_d = imem_rdata_q;
        dmem_rdata_d = dmem_rdata_q;
        imem_gnt     = 1'b0;
        dmem_gnt     = 1'b0;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    imem_gnt   = ~pick_data;
                    dmem_gnt   = pick_data;
                    last_gnt_d = pick_data;
                    tag_d      = pick_data;
                    state_d    = StIssue;
                    if (pick_data) begin
                        addr_d  = i_dmem_addr & 32'hFFFF_FFFC;
                        wen_d   = i_dmem_wen;
                        wdata_d = i_dmem_wdata;
                        mask_d  = i_dmem_mask;
                    end else begin
                        addr_d  = i_imem_addr & 32'hFFFF_FFFC;
                        wen_d   = 1'b0;
                        wdata_d = 32'h0;
                        mask_d  = 4'hF;
                    end
                end
            end
            StIssue: begin
                if (i_mem_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (i_mem_valid) begin
                    state_d = StIdle;
                    if (tag_q) begin
                        dmem_valid_d = 1'b1;
                        dmem_rdata_d = wen_q ? 32'h0 : i_mem_rdata;
                    end else begin
                        imem_valid_d = 1'b1;
                        imem_rdata_d = i_mem_rdata;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StIdle;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wen_q        <= 1'b0;
            mask_q       <= 4'h0;
            tag_q        <= 1'b0;
            last_gnt_q   <= 1'b0;
            imem_valid_q <= 1'b0;
            dmem_valid_q <= 1'b0;
            imem_rdata_q <= 32'h0;
            dmem_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wen_q        <= wen_d;
            mask_q       <= mask_d;
            tag_q        <= tag_d;
            last_gnt_q   <= last_gnt_d;
            imem_valid_q <= imem_valid_d;
            dmem_valid_q <= dmem_valid_d;
            imem_rdata_q <= imem_rdata_d;
            dmem_rdata_q <= dmem_rdata_d;
        end
    end

    // Grants are combinational from the requests, so mask them while reset is held.
    assign o_imem_gnt   = imem_gnt & ~i_rst;
    assign o_dmem_gnt   = dmem_gnt & ~i_rst;
    assign o_imem_valid = imem_valid_q;
    assign o_imem_rdata = imem_rdata_q;
    assign o_dmem_valid = dmem_valid_q;
    assign o_dmem_rdata = dmem_rdata_q;
    assign o_mem_req    = (state_q == StIssue);
    assign o_mem_addr   = addr_q;
    assign o_mem_wen    = wen_q;
    assign o_mem_wdata  = wdata_q;
    assign o_mem_mask   = mask_q;
    assign o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance per tie-break policy (index = PRIORITY_DATA), driven by
// directed steps then random traffic, checked against a transaction-level model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst        [2];
    logic        imem_req   [2];
    logic [31:0] imem_addr  [2];
    logic        imem_gnt   [2];
    logic        imem_valid [2];
    logic [31:0] imem_rdata [2];
    logic        dmem_req   [2];
    logic [31:0] dmem_addr  [2];
    logic        dmem_wen   [2];
    logic [31:0] dmem_wdata [2];
    logic [3:0]  dmem_mask  [2];
    logic        dmem_gnt   [2];
    logic        dmem_valid [2];
    logic [31:0] dmem_rdata [2];
    logic        mem_req    [2];
    logic [31:0] mem_addr   [2];
    logic        mem_wen    [2];
    logic [31:0] mem_wdata  [2];
    logic [3:0]  mem_mask   [2];
    logic        mem_ready  [2];
    logic        mem_valid  [2];
    logic [31:0] mem_rdata  [2];
    logic        busy       [2];

    int checks = 0;
    int errors = 0;

    // Model state: last winner (1 = data), expected pulse (0 none, 1 fetch, 2 data), rdata.
    bit          last_data [2];
    int          exp_pulse [2];
    logic [31:0] exp_irdata [2];
    logic [31:0] exp_drdata [2];
    bit          noise;

    mem_arbiter #(.PRIORITY_DATA(1'b0)) u_rr (
        .i_clk(clk), .i_rst(rst[0]),
        .i_imem_req(imem_req[0]), .i_imem_addr(imem_addr[0]), .o_imem_gnt(imem_gnt[0]),
        .o_imem_valid(imem_valid[0]), .o_imem_rdata(imem_rdata[0]),
        .i_dmem_req(dmem_req[0]), .i_dmem_addr(dmem_addr[0]), .i_dmem_wen(dmem_wen[0]),
        .i_dmem_wdata(dmem_wdata[0]), .i_dmem_mask(dmem_mask[0]), .o_dmem_gnt(dmem_gnt[0]),
        .o_dmem_valid(dmem_valid[0]), .o_dmem_rdata(dmem_rdata[0]),
        .o_mem_req(mem_req[0]), .o_mem_addr(mem_addr[0]), .o_mem_wen(mem_wen[0]),
        .o_mem_wdata(mem_wdata[0]), .o_mem_mask(mem_mask[0]), .i_mem_ready(mem_ready[0]),
        .i_mem_valid(mem_valid[0]), .i_mem_rdata(mem_rdata[0]), .o_busy(busy[0])
    );

    mem_arbiter #(.PRIORITY_DATA(1'b1)) u_pd (
        .i_clk(clk), .i_rst(rst[1]),
        .i_imem_req(imem_req[1]), .i_imem_addr(imem_addr[1]), .o_imem_gnt(imem_gnt[1]),
        .o_imem_valid(imem_valid[1]), .o_imem_rdata(imem_rdata[1]),
        .i_dmem_req(dmem_req[1]), .i_dmem_addr(dmem_addr[1]), .i_dmem_wen(dmem_wen[1]),
        .i_dmem_wdata(dmem_wdata[1]), .i_dmem_mask(dmem_mask[1]), .o_dmem_gnt(dmem_gnt[1]),
        .o_dmem_valid(dmem_valid[1]), .o_dmem_rdata(dmem_rdata[1]),
        .o_mem_req(mem_req[1]), .o_mem_addr(mem_addr[1]), .o_mem_wen(mem_wen[1]),
        .o_mem_wdata(mem_wdata[1]), .o_mem_mask(mem_mask[1]), .i_mem_ready(mem_ready[1]),
        .i_mem_valid(mem_valid[1]), .i_mem_rdata(mem_rdata[1]), .o_busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    // Pulse and rdata registers are checked every sampled cycle; a pulse is owed exactly once.
    task automatic check_resp(input int k);
        chk("imem_valid", k, imem_valid[k], exp_pulse[k] == 1);
        chk("dmem_valid", k, dmem_valid[k], exp_pulse[k] == 2);
        chk("imem_rdata", k, imem_rdata[k], exp_irdata[k]);
        chk("dmem_rdata", k, dmem_rdata[k], exp_drdata[k]);
        exp_pulse[k] = 0;
    endtask

    task automatic check_zero(input int k);
        chk("rst_imem_gnt", k, imem_gnt[k], 0);
        chk("rst_dmem_gnt", k, dmem_gnt[k], 0);
        chk("rst_mem_req", k, mem_req[k], 0);
        chk("rst_mem_addr", k, mem_addr[k], 0);
        chk("rst_mem_wen", k, mem_wen[k], 0);
        chk("rst_mem_wdata", k, mem_wdata[k], 0);
        chk("rst_mem_mask", k, mem_mask[k], 0);
        chk("rst_busy", k, busy[k], 0);
        last_data[k]  = 1'b0;
        exp_pulse[k]  = 0;
        exp_irdata[k] = 32'h0;
        exp_drdata[k] = 32'h0;
        check_resp(k);
    endtask

    function automatic bit pick_data(input int k);
        if (!imem_req[k]) return 1'b1;
        if (!dmem_req[k]) return 1'b0;
        if (k == 1) return 1'b1;
        return !last_data[k];
    endfunction

    // Called just after a rising edge with the DUT idle; returns in the response-pulse cycle.
    task automatic txn(input int k, input int stall, input int vdly, input logic [31:0] rd);
        bit          wd;
        logic [31:0] ea, ewd;
        logic        ewen;
        logic [3:0]  em;
        wd   = pick_data(k);
        ea   = wd ? {dmem_addr[k][31:2], 2'b00} : {imem_addr[k][31:2], 2'b00};
        ewen = wd ? dmem_wen[k] : 1'b0;
        ewd  = wd ? dmem_wdata[k] : 32'h0;
        em   = wd ? dmem_mask[k] : 4'hF;
        @(negedge clk);
        chk("imem_gnt", k, imem_gnt[k], !wd);
        chk("dmem_gnt", k, dmem_gnt[k], wd);
        chk("idle_mem_req", k, mem_req[k], 0);
        chk("idle_busy", k, busy[k], 0);
        check_resp(k);
        last_data[k] = wd;
        @(posedge clk); #1;
        for (int i = 0; i <= stall; i++) begin
            mem_ready[k] = (i == stall);
            mem_valid[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            chk("mem_req", k, mem_req[k], 1);
            chk("mem_addr", k, mem_addr[k], ea);
            chk("mem_wen", k, mem_wen[k], ewen);
            chk("mem_wdata", k, mem_wdata[k], ewd);
            chk("mem_mask", k, mem_mask[k], em);
            chk("issue_busy", k, busy[k], 1);
            chk("issue_gnt", k, imem_gnt[k] | dmem_gnt[k], 0);
            check_resp(k);
            @(posedge clk); #1;
        end
        for (int i = 0; i <= vdly; i++) begin
            mem_valid[k] = (i == vdly);
            mem_ready[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata[k] = (i == vdly) ? rd : $urandom;
            @(negedge clk);
            chk("wait_mem_req", k, mem_req[k], 0);
            chk("wait_busy", k, busy[k], 1);
            chk("wait_gnt", k, imem_gnt[k] | dmem_gnt[k], 0);
            check_resp(k);
            @(posedge clk); #1;
        end
        mem_valid[k] = 1'b0;
        mem_ready[k] = 1'b0;
        if (wd) begin
            exp_pulse[k]  = 2;
            exp_drdata[k] = ewen ? 32'h0 : rd;
        end else begin
            exp_pulse[k]  = 1;
            exp_irdata[k] = rd;
        end
    endtask

    task automatic idle(input int k, input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_gnt", k, imem_gnt[k] | dmem_gnt[k], 0);
            chk("idle_mem_req", k, mem_req[k], 0);
            chk("idle_busy", k, busy[k], 0);
            check_resp(k);
            @(posedge clk); #1;
        end
    endtask

    task automatic set_fetch(input int k, input bit req, input logic [31:0] a);
        imem_req[k]  = req;
        imem_addr[k] = a;
    endtask

    task automatic set_data(input int k, input bit req, input logic [31:0] a, input bit w,
                            input logic [31:0] wd, input logic [3:0] m);
        dmem_req[k]   = req;
        dmem_addr[k]  = a;
        dmem_wen[k]   = w;
        dmem_wdata[k] = wd;
        dmem_mask[k]  = m;
    endtask

    initial begin
        noise = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            set_fetch(k, 1'b0, 32'h0);
            set_data(k, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
            mem_ready[k] = 1'b0;
            mem_valid[k] = 1'b0;
            mem_rdata[k] = 32'h0;
        end
        #2;
        check_zero(0);
        check_zero(1);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(posedge clk); #1;

        // Lone fetch, minimum latency.
        set_fetch(1, 1'b1, 32'h0000_0010);
        txn(1, 0, 0, 32'h0050_0093);
        set_fetch(1, 1'b0, 32'h0);
        idle(1, 1);

        // Store with misaligned low address bits; load data returned is discarded.
        set_data(1, 1'b1, 32'h0000_2003, 1'b1, 32'hAB00_0000, 4'b1000);
        txn(1, 0, 0, 32'hDEAD_BEEF);
        set_data(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        idle(1, 1);

        // Fixed data priority: data wins while held, then fetch.
        set_fetch(1, 1'b1, 32'h0000_0040);
        for (int n = 0; n < 3; n++) begin
            set_data(1, 1'b1, 32'h0000_0100 + 32'(n * 4), 1'b0, 32'h0, 4'hF);
            txn(1, 0, 0, 32'h1000_0000 + 32'(n));
        end
        set_data(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        txn(1, 0, 0, 32'h0000_0013);
        set_fetch(1, 1'b0, 32'h0);
        idle(1, 1);

        // Ready stalled 4 cycles, valid delayed 2 cycles.
        set_data(1, 1'b1, 32'h0000_3008, 1'b0, 32'h0, 4'b0011);
        txn(1, 4, 2, 32'hCAFE_F00D);
        set_data(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        idle(1, 2);

        // Round-robin with both held: D, I, D, I.
        set_fetch(0, 1'b1, 32'h0000_0200);
        set_data(0, 1'b1, 32'h0000_0800, 1'b0, 32'h0, 4'hF);
        for (int n = 0; n < 4; n++) txn(0, 0, 0, 32'h2000_0000 + 32'(n));
        set_fetch(0, 1'b0, 32'h0);
        set_data(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        idle(0, 1);

        // Reset during WAIT of a data transaction; stray valid afterwards.
        set_data(0, 1'b1, 32'h0000_0900, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        chk("pre_rst_dmem_gnt", 0, dmem_gnt[0], 1);
        @(posedge clk); #1;
        set_data(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        mem_ready[0] = 1'b1;
        @(posedge clk); #1;
        mem_ready[0] = 1'b0;
        rst[0] = 1'b1;
        #1;
        check_zero(0);
        @(negedge clk);
        rst[0] = 1'b0;
        @(posedge clk); #1;
        mem_valid[0] = 1'b1;
        mem_rdata[0] = 32'h5555_AAAA;
        @(posedge clk); #1;
        mem_valid[0] = 1'b0;
        idle(0, 2);
        set_fetch(0, 1'b1, 32'h0000_0300);
        set_data(0, 1'b1, 32'h0000_0A00, 1'b0, 32'h0, 4'hF);
        txn(0, 0, 0, 32'h3333_0000);
        set_fetch(0, 1'b0, 32'h0);
        set_data(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        idle(0, 1);

        // Random traffic: a request not granted stays held with its fields.
        noise = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 30; n++) begin
                if (!imem_req[k] || !last_data[k])
                    set_fetch(k, 1'($urandom_range(0, 1)), $urandom);
                if (!dmem_req[k] || last_data[k])
                    set_data(k, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                             $urandom, 4'($urandom_range(0, 15)));
                if (!imem_req[k] && !dmem_req[k]) dmem_req[k] = 1'b1;
                txn(k, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
            end
            set_fetch(k, 1'b0, 32'h0);
            set_data(k, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
            idle(k, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one unified, multi-cycle memory port between the hart's instruction-fetch path and its load/store path. It replaces the separate combinational imem/dmem ports once the backing memory becomes a single ready/valid device. It sits between the hart's fetch and memory stages and the memory model. It serialises accesses with one transaction outstanding, chooses a winner on conflicts, and returns each response to the requester that issued it.

## Interface

- PRIORITY_DATA, 1, tie-break policy when both requests are pending in IDLE:
  - 1: data always wins.
  - 0: round-robin; the requester not granted last wins.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous active-high.
- i_imem_req  in  1  fetch request; held with its address until granted.
- i_imem_addr  in  32  fetch address.
- o_imem_gnt  out  1  fetch request accepted this cycle.
- o_imem_valid  out  1  one-cycle pulse; o_imem_rdata is valid.
- o_imem_rdata  out  32  fetched instruction word.
- i_dmem_req  in  1  data request; held with its fields until granted.
- i_dmem_addr  in  32  data address.
- i_dmem_wen  in  1  1 = store, 0 = load.
- i_dmem_wdata  in  32  store data, already lane-shifted.
- i_dmem_mask  in  4  byte-lane mask.
- o_dmem_gnt  out  1  data request accepted this cycle.
- o_dmem_valid  out  1  one-cycle pulse; load data is valid, or the store is complete.
- o_dmem_rdata  out  32  load word; 0 for stores.
- o_mem_req  out  1  downstream request.
- o_mem_addr  out  32  downstream address; bits [1:0] forced to 0.
- o_mem_wen  out  1  downstream write enable.
- o_mem_wdata  out  32  downstream write data.
- o_mem_mask  out  4  downstream mask.
- i_mem_ready  in  1  memory accepts o_mem_req this cycle.
- i_mem_valid  in  1  memory response; asserted for both reads and writes.
- i_mem_rdata  in  32  memory read data.
- o_busy  out  1  high in ISSUE or WAIT.

## Operation

- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - If either request is high, pick the winner and assert its gnt combinationally in the same cycle.
  - Latch the winner's addr/wen/wdata/mask and a source tag. Go to ISSUE.
  - With no requests, stay in IDLE.
- **Fetch latch values:** wen=0, wdata=0, mask=4'b1111.
- **Arbitration**
  - Only one request pending: that request wins.
  - Both pending: resolved per PRIORITY_DATA.
  - The last_gnt register updates on every grant. Reset value = fetch, so data wins the first tie under round-robin.
- **ISSUE**
  - o_mem_req=1, driven from the latched fields.
  - On i_mem_ready, go to WAIT. Otherwise hold all fields stable.
- **WAIT**
  - o_mem_req=0.
  - On i_mem_valid, register i_mem_rdata into the tagged requester's rdata, pulse its valid next cycle, and go to IDLE.
  - For stores, o_dmem_rdata is set to 0.
- **Ignored inputs:** i_mem_valid outside WAIT, and i_mem_ready outside ISSUE.
- **Gnt rules**
  - Never asserted outside IDLE.
  - Never both gnts in one cycle.
- **Response path:** the rdata of the non-selected requester holds its previous value.
- **Reset**, asserted at any time, including mid-transaction:
  - State → IDLE; the in-flight transaction is dropped and never reported.
  - All outputs → 0; last_gnt → fetch.

## Timing

- Grant in cycle T (IDLE) → o_mem_req from T+1.
- Minimum response path: i_mem_ready in T+1, i_mem_valid in T+2, requester valid pulse in T+3.
- During the valid-pulse cycle the FSM is already in IDLE, so a new grant may occur in that same cycle. Back-to-back transactions therefore have a 3-cycle period.
- Ready stalls: each stalled ready cycle adds one cycle.
- Valid delay: each cycle of i_mem_valid delay adds one cycle.
- Valid pulses last exactly one cycle.
- Reset state of every output: 0.

## Test plan

- **Lone fetch:**
  - Stimulus: imem_req, addr 0x00000010; memory ready immediately, valid next cycle with 0x00500093.
  - Required: o_imem_gnt at T; o_mem_addr 0x10, mask 4'hF, wen 0 at T+1; o_imem_valid with rdata 0x00500093 at T+3.
- **Store with misaligned address bits:**
  - Stimulus: dmem addr 0x00002003, wen 1, mask 4'b1000, wdata 0xAB000000.
  - Required: o_mem_addr 0x00002000, same mask/wdata; o_dmem_valid pulse with o_dmem_rdata 0.
- **Simultaneous requests, PRIORITY_DATA=1:**
  - Stimulus: both requests held for three transactions.
  - Required: all three grants go to data while it stays asserted; fetch is granted only after data_req drops.
- **Simultaneous requests, PRIORITY_DATA=0:**
  - Stimulus: both requests held continuously.
  - Required: grants alternate D, I, D, I, with data first after reset.
- **Stalls:**
  - Stimulus: i_mem_ready held low for 4 cycles, then i_mem_valid delayed 2 cycles.
  - Required: request fields stable throughout; the response pulse arrives 6 cycles later than the minimum; exactly one pulse.
- **Reset mid-transaction:**
  - Stimulus: assert i_rst during WAIT, then a stray i_mem_valid after release.
  - Required: outputs 0 immediately; no valid pulse; the next grant follows normal IDLE rules.
